// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: widths, fetch state encoding, the fetch
// buffer entry layout and the default reset PC.
package rv_core_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch engine states: IDLE may issue, WAIT owns one live response,
  // DROP owns one response that a redirect made stale.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instruction fetch addresses are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode.
// Flush empties the buffer and overrides any push or pop in the same cycle.
module fetch_fifo
  import rv_core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               i_push,
  input  fetch_entry_t       i_data,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic               o_full,
  output logic               o_empty,
  output logic [CNT_W-1:0]   o_count,
  output fetch_entry_t       o_head
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  // A push into a full buffer is legal only when the head leaves the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  // Head reads zero when empty so stale storage never reaches decode.
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Entry storage write port.
  // NOTE: the storage array is deliberately not reset; occupancy is reset and
  // o_head masks empty slots, so clearing the data would only cost logic.
  always_ff @(posedge clk_i) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the fetch PC, issues single outstanding word reads
// over req/gnt/rvalid, buffers returned words with their PCs and hands them to
// decode over valid/ready. A redirect flushes the buffer and turns any
// in-flight response into one that is silently dropped.
module instruction_fetch
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               mem_req_o,
  output logic [XLEN-1:0]    mem_addr_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [INSTR_W-1:0] mem_rdata_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    pc_o,
  input  logic               instr_ready_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_fetch_pc_next;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] w_req_pc_next;

  logic             w_outstanding;
  logic [CNT_W:0]   w_inflight;
  logic             w_issue_ok;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  // Buffered entries plus the one possibly in flight must never exceed the
  // buffer, which is what makes overflow impossible downstream.
  assign w_outstanding = (r_state != IDLE);
  assign w_inflight    = {1'b0, w_count} + (CNT_W + 1)'(w_outstanding);
  assign w_issue_ok    = !w_full && (w_inflight < (CNT_W + 1)'(FIFO_DEPTH));

  // Request depends only on registered state plus redirect_i, so it stays
  // stable while a grant is pending.
  assign mem_req_o     = (r_state == IDLE) && w_issue_ok && !redirect_i;
  assign mem_addr_o    = r_fetch_pc;

  assign w_push_entry  = '{pc: r_req_pc, instr: mem_rdata_i};
  assign w_pop         = instr_valid_o && instr_ready_i && !redirect_i;

  assign instr_valid_o = !w_empty;
  assign instr_o       = w_head.instr;
  assign pc_o          = w_head.pc;

  // Next-state, next-PC and push decision; redirect outranks everything.
  // NOTE: every combinational output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_req_pc_next   = r_req_pc;
    w_push          = 1'b0;
    if (redirect_i) begin
      w_fetch_pc_next = word_align(redirect_pc_i);
      // A response still owed to us must be swallowed when it turns up.
      w_state_next    = (w_outstanding && !mem_rvalid_i) ? DROP : IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (mem_req_o && mem_gnt_i) begin
            w_req_pc_next   = r_fetch_pc;
            w_fetch_pc_next = r_fetch_pc + PC_STEP;
            w_state_next    = WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            w_push       = 1'b1;
            w_state_next = IDLE;
          end
        end
        DROP: begin
          if (mem_rvalid_i) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Fetch engine state, fetch PC and the PC of the outstanding request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_req_pc   <= w_req_pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a responding memory, a queue-based reference
// model of the fetch stage compared every cycle, directed scenarios with
// literal expectations, a randomized run, and a wrap-around instance.
module tb_instruction_fetch;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        rst_i, mem_req_o, mem_gnt_i, mem_rvalid_i, redirect_i;
  logic        instr_valid_o, instr_ready_i;
  logic [31:0] mem_addr_o, mem_rdata_i, redirect_pc_i, instr_o, pc_o;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .instr_ready_i(instr_ready_i)
  );

  // Wrap-around instance (RESET_PC at the top of the address space)
  logic        w_rst, w_req, w_gnt, w_rvalid, w_redirect, w_valid, w_ready;
  logic [31:0] w_addr, w_rdata, w_rpc, w_instr, w_pc;

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk_i(clk), .rst_i(w_rst),
    .mem_req_o(w_req), .mem_addr_o(w_addr), .mem_gnt_i(w_gnt),
    .mem_rvalid_i(w_rvalid), .mem_rdata_i(w_rdata),
    .redirect_i(w_redirect), .redirect_pc_i(w_rpc),
    .instr_valid_o(w_valid), .instr_o(w_instr), .pc_o(w_pc),
    .instr_ready_i(w_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory environment: responses owed, with cycles remaining until rvalid.
  typedef struct {
    logic [31:0] addr;
    int          left;
  } mem_rsp_t;
  mem_rsp_t mem_q[$];
  int       lat_max = 1;

  // Reference model: expected buffer contents, fetch PC, and whether one
  // response is owed and whether it must be thrown away.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;
  entry_t      exp_q[$];
  bit          known    = 1'b0;
  bit          inflight = 1'b0;
  bit          discard  = 1'b0;
  logic [31:0] m_pc     = 32'h0;
  logic [31:0] m_req_pc = 32'h0;

  logic [31:0] grant_addrs[$];
  logic [31:0] popped_pc[$];
  logic [31:0] popped_instr[$];

  // One clock cycle: drive at negedge, compare, advance model, cross posedge.
  task automatic step(input bit r, input bit g, input bit rdy, input bit redir,
                      input logic [31:0] rpc, input bit hold);
    bit       exp_req;
    bit       dut_grant;
    entry_t   e;
    mem_rsp_t t;
    @(negedge clk);
    rst_i         = r;
    mem_gnt_i     = g;
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    mem_rvalid_i  = (mem_q.size() > 0) && (mem_q[0].left <= 1) && !hold;
    mem_rdata_i   = mem_rvalid_i ? (mem_q[0].addr ^ XOR_PAT) : $urandom;
    #1;
    exp_req = !redir && !inflight && (exp_q.size() < DEPTH);
    if (known) begin
      if (!r) begin
        check("mem_req_o", {31'b0, mem_req_o}, {31'b0, exp_req});
        if (exp_req) check("mem_addr_o", mem_addr_o, m_pc);
      end
      check("instr_valid_o", {31'b0, instr_valid_o}, {31'b0, exp_q.size() != 0});
      check("instr_o", instr_o, (exp_q.size() != 0) ? exp_q[0].instr : 32'h0);
      check("pc_o", pc_o, (exp_q.size() != 0) ? exp_q[0].pc : 32'h0);
    end

    dut_grant = mem_req_o && g && !r;
    if (!r && instr_valid_o && rdy && !redir) begin
      popped_pc.push_back(pc_o);
      popped_instr.push_back(instr_o);
    end
    if (dut_grant) grant_addrs.push_back(mem_addr_o);

    if (r) begin
      mem_q.delete();
    end else begin
      if (mem_rvalid_i) mem_q.delete(0);
      else if (mem_q.size() > 0 && mem_q[0].left > 1) begin
        t = mem_q[0];
        t.left--;
        mem_q[0] = t;
      end
      if (dut_grant) begin
        t.addr = mem_addr_o;
        t.left = int'($urandom_range(1, lat_max));
        mem_q.push_back(t);
      end
    end

    if (r) begin
      exp_q.delete();
      inflight = 1'b0;
      discard  = 1'b0;
      m_pc     = 32'h0;
      known    = 1'b1;
    end else if (redir) begin
      exp_q.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
      if (inflight) begin
        if (mem_rvalid_i) begin
          inflight = 1'b0;
          discard  = 1'b0;
        end else begin
          discard = 1'b1;
        end
      end
    end else begin
      if (exp_q.size() != 0 && rdy) exp_q.delete(0);
      if (inflight && mem_rvalid_i) begin
        if (!discard) begin
          e.pc    = m_req_pc;
          e.instr = mem_rdata_i;
          exp_q.push_back(e);
        end
        inflight = 1'b0;
        discard  = 1'b0;
      end
      if (exp_req && g) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
        inflight = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    grant_addrs.delete();
    popped_pc.delete();
    popped_instr.delete();
  endtask

  initial begin
    rst_i = 1'b1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; instr_ready_i = 1'b0;
    w_rst = 1'b1; w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    w_redirect = 1'b0; w_rpc = 32'h0; w_ready = 1'b0;

    // Reset and steady fetch
    do_reset();
    #1;
    check("rst_valid", {31'b0, instr_valid_o}, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("steady_pops", popped_pc.size(), 32'd4);
    if (popped_pc.size() >= 4) begin
      check("steady_pc0", popped_pc[0], 32'h0000_0000);
      check("steady_pc1", popped_pc[1], 32'h0000_0004);
      check("steady_pc2", popped_pc[2], 32'h0000_0008);
      check("steady_instr0", popped_instr[0], 32'hA5A5_0000);
      check("steady_instr2", popped_instr[2], 32'hA5A5_0008);
    end

    // Backpressure
    do_reset();
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("bp_grants", grant_addrs.size(), 32'd2);
    check("bp_req", {31'b0, mem_req_o}, 32'h0);
    check("bp_pc", pc_o, 32'h0);
    check("bp_instr", instr_o, 32'hA5A5_0000);
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("bp_resume_addr", (grant_addrs.size() > 2) ? grant_addrs[2] : 32'hDEAD_DEAD, 32'h8);

    // Grant stall
    do_reset();
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check("stall_req", {31'b0, mem_req_o}, 32'h1);
    check("stall_addr", mem_addr_o, 32'h0);
    check("stall_no_grant", grant_addrs.size(), 32'd0);
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("stall_next_addr", (grant_addrs.size() > 1) ? grant_addrs[1] : 32'hDEAD_DEAD, 32'h4);

    // Redirect with response in flight
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b1);
    #1;
    check("redir_flush_valid", {31'b0, instr_valid_o}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("redir_drop_valid", {31'b0, instr_valid_o}, 32'h0);
    check("redir_req_addr", mem_addr_o, 32'h0000_0100);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check("redir_out_pc", pc_o, 32'h0000_0100);
    check("redir_out_instr", instr_o, 32'hA5A5_0100);

    // Redirect coincident with rvalid and pop
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    #1;
    check("coinc_valid", {31'b0, instr_valid_o}, 32'h0);
    check("coinc_pc", pc_o, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("coinc_next_addr", (grant_addrs.size() > 2) ? grant_addrs[2] : 32'hDEAD_DEAD, 32'h200);

    // Randomized traffic with variable latency, redirects and rare resets
    do_reset();
    lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom, $urandom_range(0, 4) == 0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Reset mid-WAIT and PC wrap on the second instance
    repeat (2) @(posedge clk);
    @(negedge clk);
    w_rst = 1'b0; w_gnt = 1'b1;
    #1;
    check("wrap_first_req", {31'b0, w_req}, 32'h1);
    check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    w_gnt = 1'b0; w_rst = 1'b1;
    #1;
    check("wrap_wait_req", {31'b0, w_req}, 32'h0);
    @(negedge clk);
    w_rst = 1'b0; w_gnt = 1'b1;
    #1;
    check("wrap_rst_valid", {31'b0, w_valid}, 32'h0);
    check("wrap_rst_instr", w_instr, 32'h0);
    check("wrap_rst_pc", w_pc, 32'h0);
    check("wrap_rst_req", {31'b0, w_req}, 32'h1);
    check("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'hDEAD_BEEF;
    #1;
    check("wrap_wait_req2", {31'b0, w_req}, 32'h0);
    @(negedge clk);
    w_rvalid = 1'b0;
    #1;
    check("wrap_out_valid", {31'b0, w_valid}, 32'h1);
    check("wrap_out_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_out_instr", w_instr, 32'hDEAD_BEEF);
    check("wrap_next_addr", w_addr, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
